// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the fetch PC, runs a single-outstanding
// request/grant/response handshake to imem, and hands words to decode.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] next_PC,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_PC,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] FULL = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] target;

  assign target = {next_PC[31:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    drop_d        = drop_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    if (redirect) begin
      // Redirect wins; an in-flight request must still retire, so its
      // response is marked for discard rather than abandoned.
      fetch_pc_d    = target;
      instr_valid_d = 1'b0;
      case (state_q)
        REQ:     if (imem_gnt) begin
                   state_d = WAIT;
                   drop_d  = 1'b1;
                 end
        WAIT:    if (imem_rvalid) begin
                   state_d = REQ;
                   drop_d  = 1'b0;
                 end else begin
                   drop_d  = 1'b1;
                 end
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ:  if (imem_gnt) state_d = WAIT;
        WAIT: if (imem_rvalid) begin
                if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
                end else begin
                  instr_d       = imem_rdata;
                  instr_pc_d    = fetch_pc_q;
                  instr_valid_d = 1'b1;
                  fetch_pc_d    = fetch_pc_q + 32'd4;
                  state_d       = FULL;
                end
              end
        default: if (instr_valid_q && instr_ready) begin
                   instr_valid_d = 1'b0;
                   state_d       = REQ;
                 end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      drop_q        <= 1'b0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      drop_q        <= drop_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign instr_PC    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch front end that owns the architectural fetch PC and feeds the decode stage. It consumes the `next_PC` produced by the next-PC logic whenever a control-flow redirect is signalled; otherwise it fetches sequentially at PC+4. It drives the instruction memory over a request/grant/response handshake and presents fetched instructions to decode through a single-entry valid/ready output register. At most one memory request is outstanding at any time.

## Interface
- `RESET_PC`, default 32'h0000_3000, first fetch address after reset (word-aligned).
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `next_PC` in 32: redirect target from next-PC logic; sampled only when `redirect`=1.
- `redirect` in 1: decode resolved a taken jump/branch; fetch restarts at `next_PC`.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, always word-aligned.
- `imem_gnt` in 1: memory accepted the request this cycle.
- `imem_rvalid` in 1: response data valid this cycle.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: instruction to decode.
- `instr_PC` out 32: address of `instr`.
- `instr_valid` out 1: output register holds an instruction.
- `instr_ready` in 1: decode accepts `instr` this cycle.

## Operation
- Registers: `fetch_PC` (32), `state`, `drop` (1), output register (`instr`, `instr_PC`, `instr_valid`).
- Redirect alignment: `fetch_PC` <= {`next_PC`[31:2], 2'b00}; low bits are ignored.
- States:
  - IDLE: entered only from reset. Next cycle -> REQ.
  - REQ: `imem_req`=1, `imem_addr`=`fetch_PC`. On `imem_gnt` -> WAIT, else stay.
  - WAIT: `imem_req`=0; await `imem_rvalid`.
    - If `drop`=1: discard data, clear `drop`, -> REQ.
    - If `drop`=0: load `instr`<=`imem_rdata`, `instr_PC`<=`fetch_PC`, `instr_valid`<=1, `fetch_PC`<=`fetch_PC`+4 (mod 2^32), -> FULL.
  - FULL: hold the output register. When `instr_valid`&&`instr_ready`: `instr_valid`<=0, -> REQ.
- Output register is loaded only in WAIT. REQ is entered only after the output is drained, so the output register is always empty when a response arrives.
- `redirect` has priority over every other event. In any state it clears `instr_valid` next cycle and loads the aligned target into `fetch_PC`. Per state:
  - IDLE or FULL: -> REQ.
  - REQ without `imem_gnt`: stay in REQ; the address changes to the target on the next cycle. The memory must tolerate an address change on an ungranted request.
  - REQ with `imem_gnt`: -> WAIT with `drop`<=1.
  - WAIT without `imem_rvalid`: `drop`<=1, stay in WAIT.
  - WAIT with `imem_rvalid`: discard the data, `drop`<=0, -> REQ.
- A `instr_valid`&&`instr_ready` handshake that coincides with `redirect` counts as transferred, because decode sampled it. The output register is still cleared.
- `imem_rvalid` outside WAIT is ignored. `imem_gnt` outside REQ is ignored.

## Timing
- Reset values (async, immediate):
  - state=IDLE, `fetch_PC`=`RESET_PC`, `drop`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr`=0, `instr_PC`=0, `instr_valid`=0.
- Asserting `reset_n` mid-transaction aborts it. No response is expected afterward, and any later `imem_rvalid` is ignored until the FSM reaches WAIT.
- First `imem_req` is the 2nd rising edge after `reset_n` deasserts (IDLE for one cycle).
- `imem_req` and `imem_addr` are registered outputs decoded from state and `fetch_PC`.
- Best case with single-cycle grant, response in the cycle after grant, and decode always ready:
  - REQ(t), WAIT(t+1) with rvalid, FULL(t+2) with `instr_valid`=1 and consumed, REQ(t+3).
  - Gives 3 cycles per instruction.
- Redirect latency: the request to the target appears the cycle after `redirect`, unless a request is in flight. In that case it appears the cycle after the stale response returns.
- `fetch_PC` wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.

## Test plan
- Reset/sequential fetch:
  - Stimulus: release `reset_n`; memory grants immediately, responds 1 cycle later with data=addr^32'hFFFF_FFFF; `instr_ready`=1.
  - Required: `instr_PC` sequence 0x3000, 0x3004, 0x3008, one every 3 cycles; `instr` matches.
- Backpressure:
  - Stimulus: hold `instr_ready`=0 for 5 cycles after the first `instr_valid`.
  - Required: `instr`/`instr_PC`=0x3000 stable and `imem_req`=0 throughout; next request to 0x3004 appears the cycle after `instr_ready` rises.
- Redirect in WAIT:
  - Stimulus: after the 0x3004 grant, pulse `redirect` with `next_PC`=0x3100 before rvalid.
  - Required: the 0x3004 response is dropped (no `instr_valid`); next `imem_addr`=0x3100; next `instr_PC`=0x3100.
- Redirect with misaligned target in FULL:
  - Stimulus: `next_PC`=0x3203 while `instr_valid`=1.
  - Required: `instr_valid`=0 next cycle; next `imem_addr`=0x3200.
- Redirect in REQ:
  - Stimulus: `imem_gnt` held low 3 cycles; `redirect` to 0x4000 in the 2nd cycle.
  - Required: `imem_addr` switches to 0x4000 next cycle with `imem_req` still 1; granted fetch returns `instr_PC`=0x4000.
- Reset mid-WAIT:
  - Stimulus: drop `reset_n` while in WAIT, then a late `imem_rvalid` arrives during the IDLE cycle.
  - Required: all outputs at reset values immediately; the late response is ignored; first request is 0x3000.
